// File: rtl/lpif_rx_pkg.sv
// Shared types and helpers for the LPIF RX framer: packet context encoding,
// generation limits and a saturating adder for the statistics counters.
package lpif_rx_pkg;

    typedef enum logic [1:0] {
        CTX_IDLE = 2'd0,
        CTX_TLP  = 2'd1,
        CTX_DLLP = 2'd2
    } ctx_e;

    localparam logic [3:0] ST_ACTIVE_DEFAULT = 4'd2;
    localparam logic [2:0] GEN_MIN           = 3'd1;
    localparam logic [2:0] GEN_MAX           = 3'd5;
    localparam int unsigned SAT_W            = 32;

    // Adds b to a and clamps the result at max_v.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input logic [SAT_W-1:0] max_v);
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/lpif_rx_byte_ctx.sv
// Single-byte framing step: advances the packet context by one byte and
// flags violations and completed TLP/DLLP/nullified packets.
module lpif_rx_byte_ctx
    import lpif_rx_pkg::*;
(
    input  ctx_e ctx_in,
    input  logic valid,
    input  logic tlpstart,
    input  logic dllpstart,
    input  logic tlpend,
    input  logic dllpend,
    input  logic edb,
    output ctx_e ctx_out,
    output logic err,
    output logic inc_tlp,
    output logic inc_dllp,
    output logic inc_null
);

    logic [2:0] nflags;

    assign nflags = 3'(tlpstart) + 3'(dllpstart) + 3'(tlpend) + 3'(dllpend) + 3'(edb);

    always_comb begin
        ctx_out  = ctx_in;
        err      = 1'b0;
        inc_tlp  = 1'b0;
        inc_dllp = 1'b0;
        inc_null = 1'b0;
        if (!valid) begin
            // Flags on an invalid byte are dropped and leave the context alone.
            err = (nflags != 3'd0);
        end else if (nflags > 3'd1) begin
            err     = 1'b1;
            ctx_out = CTX_IDLE;
        end else if (tlpstart) begin
            err     = (ctx_in != CTX_IDLE);
            ctx_out = CTX_TLP;
        end else if (dllpstart) begin
            err     = (ctx_in != CTX_IDLE);
            ctx_out = CTX_DLLP;
        end else if (tlpend) begin
            if (ctx_in == CTX_TLP) begin
                ctx_out = CTX_IDLE;
                inc_tlp = 1'b1;
            end else begin
                err = 1'b1;
            end
        end else if (edb) begin
            if (ctx_in == CTX_TLP) begin
                ctx_out  = CTX_IDLE;
                inc_null = 1'b1;
            end else begin
                err = 1'b1;
            end
        end else if (dllpend) begin
            if (ctx_in == CTX_DLLP) begin
                ctx_out  = CTX_IDLE;
                inc_dllp = 1'b1;
            end else begin
                err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lpif_rx_framer.sv
// LPIF RX framer: registers one flit per cycle onto the pl_* interface, tracks
// packet context across flits, and keeps saturating framing statistics.
module lpif_rx_framer
    import lpif_rx_pkg::*;
#(
    parameter int unsigned NBYTES    = 64,
    parameter int unsigned CNT_W     = 16,
    parameter logic [3:0]  ST_ACTIVE = ST_ACTIVE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*NBYTES-1:0]   packetData,
    input  logic [NBYTES-1:0]     packetValid,
    input  logic [NBYTES-1:0]     tlpstart,
    input  logic [NBYTES-1:0]     dllpstart,
    input  logic [NBYTES-1:0]     tlpend,
    input  logic [NBYTES-1:0]     dllpend,
    input  logic [NBYTES-1:0]     edb,
    input  logic [2:0]            GEN,
    input  logic [3:0]            state,
    input  logic                  lp_force_detect,
    output logic [8*NBYTES-1:0]   pl_data,
    output logic [NBYTES-1:0]     pl_valid,
    output logic [NBYTES-1:0]     pl_tlpstart,
    output logic [NBYTES-1:0]     pl_dllpstart,
    output logic [NBYTES-1:0]     pl_tlpend,
    output logic [NBYTES-1:0]     pl_dllpend,
    output logic [NBYTES-1:0]     pl_tlpedb,
    output logic [2:0]            pl_speedmode,
    output logic [3:0]            pl_state_sts,
    output logic                  ltssmForceDetect,
    output logic                  pl_frame_err,
    output logic [CNT_W-1:0]      tlp_count,
    output logic [CNT_W-1:0]      dllp_count,
    output logic [CNT_W-1:0]      nullified_count,
    output logic [CNT_W-1:0]      err_count
);

    localparam int unsigned DW    = 8 * NBYTES;
    localparam int unsigned INC_W = $clog2(NBYTES + 1);
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'((33'd1 << CNT_W) - 33'd1);

    ctx_e ctx_q, ctx_d;
    logic active_c;
    logic [NBYTES-1:0] err_v, tlp_v, dllp_v, null_v;
    logic [INC_W-1:0]  n_err, n_tlp, n_dllp, n_null;

    logic [DW-1:0]     data_q, data_d;
    logic [NBYTES-1:0] valid_q, valid_d, ts_q, ts_d, ds_q, ds_d;
    logic [NBYTES-1:0] te_q, te_d, de_q, de_d, edb_q, edb_d;
    logic [2:0]        spd_q, spd_d;
    logic [3:0]        sts_q;
    logic              fd_q, ferr_q, ferr_d;
    logic [CNT_W-1:0]  tlp_q, tlp_d, dllp_q, dllp_d, null_q, null_d, err_q, err_d;

    assign active_c = (state == ST_ACTIVE);

    // Byte chain runs from the first-on-wire lane (NBYTES-1) down to lane 0.
    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
        ctx_e ctx_i;
        ctx_e ctx_o;
        if (i == NBYTES - 1) begin : g_first
            assign ctx_i = ctx_q;
        end else begin : g_next
            assign ctx_i = g_byte[i+1].ctx_o;
        end
        lpif_rx_byte_ctx u_step (
            .ctx_in   (ctx_i),
            .valid    (packetValid[i]),
            .tlpstart (tlpstart[i]),
            .dllpstart(dllpstart[i]),
            .tlpend   (tlpend[i]),
            .dllpend  (dllpend[i]),
            .edb      (edb[i]),
            .ctx_out  (ctx_o),
            .err      (err_v[i]),
            .inc_tlp  (tlp_v[i]),
            .inc_dllp (dllp_v[i]),
            .inc_null (null_v[i])
        );
    end

    always_comb begin
        n_err  = '0;
        n_tlp  = '0;
        n_dllp = '0;
        n_null = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            n_err  = n_err  + INC_W'(err_v[i]);
            n_tlp  = n_tlp  + INC_W'(tlp_v[i]);
            n_dllp = n_dllp + INC_W'(dllp_v[i]);
            n_null = n_null + INC_W'(null_v[i]);
        end
    end

    // Context FSM: outside the active state the context is parked in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) ctx_q <= CTX_IDLE;
        else        ctx_q <= ctx_d;
    end

    always_comb begin
        ctx_d = CTX_IDLE;
        if (active_c) ctx_d = g_byte[0].ctx_o;
    end

    always_comb begin
        valid_d = active_c ? packetValid : '0;
        data_d  = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            data_d[8*i +: 8] = valid_d[i] ? packetData[8*i +: 8] : 8'h00;
        end
        ts_d   = tlpstart  & valid_d;
        ds_d   = dllpstart & valid_d;
        te_d   = tlpend    & valid_d;
        de_d   = dllpend   & valid_d;
        edb_d  = edb       & valid_d;
        spd_d  = (GEN >= GEN_MIN && GEN <= GEN_MAX) ? GEN : spd_q;
        ferr_d = active_c && (n_err != '0);
        tlp_d  = tlp_q;
        dllp_d = dllp_q;
        null_d = null_q;
        err_d  = err_q;
        if (active_c) begin
            tlp_d  = CNT_W'(sat_add(SAT_W'(tlp_q),  SAT_W'(n_tlp),  CNT_MAX));
            dllp_d = CNT_W'(sat_add(SAT_W'(dllp_q), SAT_W'(n_dllp), CNT_MAX));
            null_d = CNT_W'(sat_add(SAT_W'(null_q), SAT_W'(n_null), CNT_MAX));
            err_d  = CNT_W'(sat_add(SAT_W'(err_q),  SAT_W'(n_err),  CNT_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= '0;
            ts_q    <= '0;
            ds_q    <= '0;
            te_q    <= '0;
            de_q    <= '0;
            edb_q   <= '0;
            spd_q   <= 3'd1;
            sts_q   <= '0;
            fd_q    <= 1'b0;
            ferr_q  <= 1'b0;
            tlp_q   <= '0;
            dllp_q  <= '0;
            null_q  <= '0;
            err_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ts_q    <= ts_d;
            ds_q    <= ds_d;
            te_q    <= te_d;
            de_q    <= de_d;
            edb_q   <= edb_d;
            spd_q   <= spd_d;
            sts_q   <= state;
            fd_q    <= lp_force_detect;
            ferr_q  <= ferr_d;
            tlp_q   <= tlp_d;
            dllp_q  <= dllp_d;
            null_q  <= null_d;
            err_q   <= err_d;
        end
    end

    assign pl_data          = data_q;
    assign pl_valid         = valid_q;
    assign pl_tlpstart      = ts_q;
    assign pl_dllpstart     = ds_q;
    assign pl_tlpend        = te_q;
    assign pl_dllpend       = de_q;
    assign pl_tlpedb        = edb_q;
    assign pl_speedmode     = spd_q;
    assign pl_state_sts     = sts_q;
    assign ltssmForceDetect = fd_q;
    assign pl_frame_err     = ferr_q;
    assign tlp_count        = tlp_q;
    assign dllp_count       = dllp_q;
    assign nullified_count  = null_q;
    assign err_count        = err_q;

endmodule
